// File: rtl/riscv_test_sequencer.sv
// Host-side test-injection driver: buffers an instruction pattern, flushes the CPU,
// feeds the pattern by CPU PC index, drains, reads back test_value and checks it.
module riscv_test_sequencer #(
   parameter int          DEPTH         = 16,
   parameter int          FLUSH_CYCLES  = 2,
   parameter int          DRAIN_CYCLES  = 6,
   parameter int          READ_CYCLES   = 2,
   parameter int          ISSUE_TIMEOUT = 64,
   parameter logic [31:0] NOP           = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       Rst,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [31:0]                load_data,
   input  logic                       load_clear,
   input  logic [31:0]                expected,
   input  logic                       start,
   input  logic [31:0]                cpu_pc,
   input  logic [31:0]                test_value,
   output logic                       test_start,
   output logic                       CPU_restart,
   output logic                       PC_restart,
   output logic                       inst_end,
   output logic [31:0]                test_pattern,
   output logic [$clog2(DEPTH)-1:0]   pattern_count,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       timeout,
   output logic [31:0]                result
);

   localparam int IDX_W   = $clog2(DEPTH);
   localparam int MAX_FD  = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
   localparam int MAX_RT  = (READ_CYCLES > ISSUE_TIMEOUT) ? READ_CYCLES : ISSUE_TIMEOUT;
   localparam int CNT_MAX = (MAX_FD > MAX_RT) ? MAX_FD : MAX_RT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_ISSUE,
      S_DRAIN,
      S_READ,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   count_q, count_d;
   logic [31:0]        expected_q, expected_d;
   logic [31:0]        result_q, result_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               timeout_q, timeout_d;
   logic               wr_en;
   logic               idle_like;
   logic               pc_in_range;
   logic [31:0]        mem_q [DEPTH];

   assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
   assign load_ready  = idle_like && (count_q < IDX_W'(DEPTH - 1));
   assign pc_in_range = cpu_pc < {{(32 - IDX_W){1'b0}}, count_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      count_d    = count_q;
      expected_d = expected_q;
      result_d   = result_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      wr_en      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            cnt_d = '0;
            if (load_clear) begin
               count_d = '0;
            end else if (load_valid && load_ready) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
            end
            // A clear in the same cycle would leave the run with an empty buffer.
            if (start && (count_q != '0) && !load_clear) begin
               state_d    = S_FLUSH;
               expected_d = expected;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         S_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
            end
         end
         S_ISSUE: begin
            if (!pc_in_range) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(ISSUE_TIMEOUT - 1)) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_d = S_READ;
               cnt_d   = '0;
            end
         end
         S_READ: begin
            if (cnt_q == CNT_W'(READ_CYCLES - 1)) begin
               state_d  = S_DONE;
               result_d = test_value;
               pass_d   = (test_value == expected_q);
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control outputs decode the registered state; test_pattern alone also follows cpu_pc.
   always_comb begin
      test_start   = 1'b0;
      CPU_restart  = 1'b0;
      PC_restart   = 1'b0;
      inst_end     = 1'b0;
      test_pattern = '0;
      busy         = 1'b0;
      case (state_q)
         S_FLUSH: begin
            test_start   = 1'b1;
            test_pattern = NOP;
            busy         = 1'b1;
         end
         S_ISSUE: begin
            test_start   = 1'b1;
            CPU_restart  = 1'b1;
            PC_restart   = 1'b1;
            test_pattern = pc_in_range ? mem_q[cpu_pc[IDX_W-1:0]] : NOP;
            busy         = 1'b1;
         end
         S_DRAIN: begin
            test_start   = 1'b1;
            CPU_restart  = 1'b1;
            PC_restart   = 1'b1;
            test_pattern = NOP;
            busy         = 1'b1;
         end
         S_READ: begin
            test_start   = 1'b1;
            CPU_restart  = 1'b1;
            PC_restart   = 1'b1;
            inst_end     = 1'b1;
            test_pattern = NOP;
            busy         = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign pattern_count = count_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign timeout       = timeout_q;
   assign result        = result_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[count_q] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         count_q    <= '0;
         expected_q <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         count_q    <= count_d;
         expected_q <= expected_d;
         result_q   <= result_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Directed bench for riscv_test_sequencer: reset, normal runs, PC stall, buffer full,
// empty start, issue timeout and mid-run reset.
module tb_riscv_test_sequencer;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        Rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_data = '0;
   logic        load_clear = 1'b0;
   logic [31:0] expected = '0;
   logic        start = 1'b0;
   logic [31:0] cpu_pc = '0;
   logic [31:0] test_value = '0;
   logic        test_start, CPU_restart, PC_restart, inst_end;
   logic [31:0] test_pattern;
   logic [3:0]  pattern_count;
   logic        busy, done, pass, timeout;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   logic [31:0] pat [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

   always #5 clk = ~clk;

   riscv_test_sequencer dut (
      .clk(clk), .Rst(Rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_clear(load_clear), .expected(expected), .start(start),
      .cpu_pc(cpu_pc), .test_value(test_value), .test_start(test_start),
      .CPU_restart(CPU_restart), .PC_restart(PC_restart), .inst_end(inst_end),
      .test_pattern(test_pattern), .pattern_count(pattern_count), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .result(result)
   );

   task automatic do_reset();
      Rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 Rst = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w);
      load_data  = w;
      load_valid = 1'b1;
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({test_start, CPU_restart, PC_restart, inst_end, busy, done, pass, timeout} !== 8'h00
          || test_pattern !== 32'h0 || result !== 32'h0 || pattern_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_outputs ctl=%b pat=%h res=%h cnt=%0d want all zero",
                  {test_start, CPU_restart, PC_restart, inst_end, busy, done, pass, timeout},
                  test_pattern, result, pattern_count);
      end
      @(posedge clk);
      #1 Rst = 1'b0;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_load_ready got=%b want=1", load_ready);
      end
      $display("reset: checked outputs in and after reset");
   endtask

   // Runs the 3-word pattern; hold1 extra cycles with cpu_pc stuck at 1.
   task automatic run_pattern(input int hold1, input logic [31:0] tv, input logic [31:0] exp_v);
      int pc;
      int held;
      logic [31:0] want;
      expected = exp_v;
      cpu_pc   = '0;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({test_start, CPU_restart, PC_restart, busy} !== 4'b1001 || test_pattern !== NOP) begin
            errors++;
            $display("FAIL flush_ctl cyc=%0d ts/cr/pr/busy=%b pat=%h want 1001 %h",
                     i, {test_start, CPU_restart, PC_restart, busy}, test_pattern, NOP);
         end
         @(posedge clk);
         #1;
      end
      pc   = 0;
      held = 0;
      while (pc <= 3) begin
         want = (pc < 3) ? pat[pc] : NOP;
         @(negedge clk);
         checks++;
         if (test_pattern !== want || {test_start, CPU_restart, PC_restart, inst_end} !== 4'b1110) begin
            errors++;
            $display("FAIL issue_pattern pc=%0d pat=%h ctl=%b want %h 1110",
                     pc, test_pattern, {test_start, CPU_restart, PC_restart, inst_end}, want);
         end
         @(posedge clk);
         #1;
         if (pc == 1 && held < hold1) held++;
         else pc++;
         cpu_pc = pc;
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (test_pattern !== NOP || {test_start, CPU_restart, PC_restart, inst_end} !== 4'b1110) begin
            errors++;
            $display("FAIL drain cyc=%0d pat=%h ctl=%b want %h 1110",
                     i, test_pattern, {test_start, CPU_restart, PC_restart, inst_end}, NOP);
         end
         @(posedge clk);
         #1;
      end
      test_value = ~tv;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (inst_end !== 1'b1 || test_start !== 1'b1 || test_pattern !== NOP) begin
            errors++;
            $display("FAIL read cyc=%0d inst_end=%b ts=%b pat=%h want 1 1 %h",
                     i, inst_end, test_start, test_pattern, NOP);
         end
         @(posedge clk);
         #1 test_value = tv;
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || pass !== (tv == exp_v) || timeout !== 1'b0 || result !== tv
          || busy !== 1'b0 || test_start !== 1'b0 || inst_end !== 1'b0) begin
         errors++;
         $display("FAIL done_state done=%b pass=%b to=%b res=%h busy=%b ts=%b ie=%b want 1 %b 0 %h 0 0 0",
                  done, pass, timeout, result, busy, test_start, inst_end, (tv == exp_v), tv);
      end
      $display("run: hold=%0d tv=%h exp=%h done=%b pass=%b result=%h", hold1, tv, exp_v, done, pass, result);
   endtask

   task automatic test_run();
      for (int i = 0; i < 3; i++) load_word(pat[i]);
      @(negedge clk);
      checks++;
      if (pattern_count !== 4'd3) begin
         errors++;
         $display("FAIL load_count got=%0d want=3", pattern_count);
      end
      run_pattern(0, 32'h0000000F, 32'h0000000F);
   endtask

   task automatic test_stall_rerun();
      run_pattern(2, 32'h0000000E, 32'h0000000F);
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (load_ready !== (i < 15)) begin
            errors++;
            $display("FAIL full_ready word=%0d got=%b want=%b", i, load_ready, (i < 15));
         end
         @(posedge clk);
         #1;
         load_word(32'h10000000 + i);
      end
      @(negedge clk);
      checks++;
      if (pattern_count !== 4'd15 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_count cnt=%0d ready=%b want 15 0", pattern_count, load_ready);
      end
      $display("full: offered 16 words count=%0d ready=%b", pattern_count, load_ready);
   endtask

   task automatic test_timeout();
      int n;
      expected   = 32'h0;
      test_value = 32'h0;
      cpu_pc     = 32'd14;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) break;
         checks++;
         if (test_pattern !== 32'h1000000E || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_issue cyc=%0d pat=%h busy=%b want 1000000e 1", n, test_pattern, busy);
         end
         n++;
      end
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL timeout_cycles got=%0d want=64", n);
      end
      checks++;
      if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || test_start !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags done=%b to=%b pass=%b ts=%b busy=%b want 1 1 0 0 0",
                  done, timeout, pass, test_start, busy);
      end
      cpu_pc = '0;
      $display("timeout: issue cycles=%0d done=%b timeout=%b pass=%b", n, done, timeout, pass);
   endtask

   task automatic test_clear_empty_start();
      do_reset();
      load_word(pat[0]);
      load_word(pat[1]);
      load_data  = pat[2];
      load_valid = 1'b1;
      load_clear = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (pattern_count !== 4'd0) begin
         errors++;
         $display("FAIL clear_count got=%0d want=0", pattern_count);
      end
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || test_start !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL empty_start busy=%b ts=%b done=%b ready=%b want 0 0 0 1",
                  busy, test_start, done, load_ready);
      end
      $display("clear: count=%0d start ignored busy=%b", pattern_count, busy);
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 3; i++) load_word(pat[i]);
      cpu_pc = '0;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (test_pattern !== pat[0] || PC_restart !== 1'b1) begin
         errors++;
         $display("FAIL midrun_issue pat=%h pr=%b want %h 1", test_pattern, PC_restart, pat[0]);
      end
      Rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({test_start, CPU_restart, PC_restart, inst_end, busy, done, pass, timeout} !== 8'h00
          || test_pattern !== 32'h0 || pattern_count !== 4'd0) begin
         errors++;
         $display("FAIL midrun_reset ctl=%b pat=%h cnt=%0d want all zero",
                  {test_start, CPU_restart, PC_restart, inst_end, busy, done, pass, timeout},
                  test_pattern, pattern_count);
      end
      #1 Rst = 1'b0;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_ready got=%b want=1", load_ready);
      end
      $display("midrun: reset during issue returned to idle");
   endtask

   initial begin
      test_reset();
      test_run();
      test_stall_rerun();
      test_full();
      test_timeout();
      test_clear_empty_start();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
